hex_scan_display: RTL

HEX_SCAN_DISPLAY -- requirements
Module: hex_scan_display

---
 rtl/hex_scan_display.sv | 119 +++++++++++
 1 files changed

// File: rtl/hex_scan_display.sv
// rtl/hex_scan_display.sv - multiplexed hex display scanner with load handshake, zero blanking and blink
module hex_scan_display #(
    parameter int DIGITS       = 8,
    parameter int DIV          = 1000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  blank_lz,
    input  logic [DIGITS-1:0]     blink_mask,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  frame_done
);

    localparam int SW = $clog2(DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [SW-1:0]       slot;
    logic [IW-1:0]       idx;
    logic [FW-1:0]       fcnt;
    logic                blink_phase;
    logic [4*DIGITS-1:0] disp;
    logic [4*DIGITS-1:0] pend;
    logic                pend_valid;
    logic                tick;
    logic                boundary;
    logic [3:0]          nib;
    logic                upper_zero;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    assign tick     = (slot == SW'(DIV - 1));
    assign boundary = tick && (idx == IW'(DIGITS - 1));
    assign in_ready = !pend_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot        <= '0;
            idx         <= '0;
            fcnt        <= '0;
            blink_phase <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            slot       <= tick ? '0 : slot + 1'b1;
            frame_done <= boundary;
            if (tick) begin
                idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
            end
            if (boundary) begin
                if (fcnt == FW'(BLINK_FRAMES - 1)) begin
                    fcnt        <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    fcnt <= fcnt + 1'b1;
                end
            end
        end
    end

    // New data only reaches the display at a frame edge, so a frame never shows mixed values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp       <= '0;
            pend       <= '0;
            pend_valid <= 1'b0;
        end else if (boundary && pend_valid) begin
            disp       <= pend;
            pend_valid <= 1'b0;
        end else if (in_valid && !pend_valid) begin
            pend       <= in_data;
            pend_valid <= 1'b1;
        end
    end

    always_comb begin
        nib        = disp[{idx, 2'b00} +: 4];
        upper_zero = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (IW'(i) >= idx && disp[4*i +: 4] != 4'h0) begin
                upper_zero = 1'b0;
            end
        end
        an  = '1;
        seg = 7'h7F;
        // Slot 0 of every digit is dead time to avoid ghosting between digits.
        if (slot != '0) begin
            an = ~(DIGITS'(1) << idx);
            if (!(blink_phase && blink_mask[idx]) &&
                !(blank_lz && idx != '0 && upper_zero)) begin
                seg = hex7(nib);
            end
        end
    end

endmodule
